// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin front end for a fixed-latency MAC datapath with
// credit-checked per-requester result FIFOs. Define MAC_ARB_STATS_EN for grant counters.
module mac_arbiter #(
  parameter int LAT    = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              mac_in_valid,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [DATA_W-1:0] mac_out,
  output logic              res0_valid,
  input  logic              res0_ready,
  output logic [DATA_W-1:0] res0_data,
  output logic              res1_valid,
  input  logic              res1_ready,
  output logic [DATA_W-1:0] res1_data,
`ifdef MAC_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]          req_valid, res_ready, elig, gnt, push, pop;
  logic [1:0][CW-1:0]  count_q, count_d, inflight_q, inflight_d;
  logic [1:0][AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0]   mem_q [2][DEPTH];
  logic                last_grant_q;
  logic                mac_in_valid_q, mac_tag_q;
  logic [DATA_W-1:0]   mac_a_q, mac_b_q;
  logic [LAT-1:0]      sr_v_q, sr_tag_q;

  assign req_valid = {req1_valid, req0_valid};
  assign res_ready = {res1_ready, res0_ready};

  // Credit check counts results already queued plus those still in the datapath,
  // so a push can never find its FIFO full.
  always_comb begin
    elig       = '0;
    gnt        = '0;
    push       = '0;
    pop        = '0;
    count_d    = count_q;
    inflight_d = inflight_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    for (int n = 0; n < 2; n++) begin
      elig[n] = req_valid[n] &&
                (({1'b0, count_q[n]} + {1'b0, inflight_q[n]}) < (CW+1)'(DEPTH));
    end
    if (rst) begin
      gnt = 2'b00;
    end else if (&elig) begin
      gnt = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      gnt = elig;
    end
    push[0] = sr_v_q[LAT-1] & ~sr_tag_q[LAT-1];
    push[1] = sr_v_q[LAT-1] &  sr_tag_q[LAT-1];
    for (int n = 0; n < 2; n++) begin
      pop[n]        = (count_q[n] != '0) & res_ready[n];
      count_d[n]    = count_q[n] + CW'(push[n]) - CW'(pop[n]);
      inflight_d[n] = inflight_q[n] + CW'(gnt[n]) - CW'(push[n]);
      wr_d[n]       = wr_q[n] + AW'(push[n]);
      rd_d[n]       = rd_q[n] + AW'(pop[n]);
    end
  end

  // Control state: counters, pointers, issue register and the valid/tag shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      inflight_q     <= '0;
      wr_q           <= '0;
      rd_q           <= '0;
      last_grant_q   <= 1'b1;
      mac_in_valid_q <= 1'b0;
      mac_tag_q      <= 1'b0;
      mac_a_q        <= '0;
      mac_b_q        <= '0;
      sr_v_q         <= '0;
      sr_tag_q       <= '0;
    end else begin
      count_q        <= count_d;
      inflight_q     <= inflight_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      mac_in_valid_q <= |gnt;
      if (|gnt) begin
        last_grant_q <= gnt[1];
        mac_tag_q    <= gnt[1];
        mac_a_q      <= gnt[1] ? req1_a : req0_a;
        mac_b_q      <= gnt[1] ? req1_b : req0_b;
      end
      sr_v_q   <= {sr_v_q[LAT-2:0], mac_in_valid_q};
      sr_tag_q <= {sr_tag_q[LAT-2:0], mac_tag_q};
    end
  end

  // FIFO storage needs no reset; the counts decide what is visible.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_q[n][wr_q[n]] <= mac_out;
      end
    end
  end

  assign req0_ready   = gnt[0];
  assign req1_ready   = gnt[1];
  assign mac_in_valid = mac_in_valid_q;
  assign mac_a        = mac_a_q;
  assign mac_b        = mac_b_q;
  assign res0_valid   = (count_q[0] != '0);
  assign res1_valid   = (count_q[1] != '0);
  assign res0_data    = res0_valid ? mem_q[0][rd_q[0]] : '0;
  assign res1_data    = res1_valid ? mem_q[1][rd_q[1]] : '0;
  assign busy         = (inflight_q != '0) || (count_q != '0);

`ifdef MAC_ARB_STATS_EN
  logic [1:0][15:0] grant_cnt_q;

  // Saturating per-requester transfer counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (gnt[n] && (grant_cnt_q[n] != 16'hFFFF)) begin
          grant_cnt_q[n] <= grant_cnt_q[n] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt0 = grant_cnt_q[0];
  assign grant_cnt1 = grant_cnt_q[1];
`endif
endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameters SHALL be: LAT, default 5, MAC datapath latency in cycles from mac_in_valid to mac_out; DATA_W, default 16, FP16 operand/result width; DEPTH, default 4, per-requester result FIFO entries (power of two).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 reqN_valid / reqN_ready  in/out  1 each  operand handshake, requester N in {0,1}.
REQ-005 reqN_a, reqN_b  in  DATA_W  FP16 operands of requester N.
REQ-006 mac_in_valid  out  1  registered issue strobe to the MAC datapath.
REQ-007 mac_a, mac_b  out  DATA_W  registered operands to the MAC datapath.
REQ-008 mac_out  in  DATA_W  datapath result, valid exactly LAT cycles after the matching mac_in_valid cycle.
REQ-009 resN_valid / resN_ready  out/in  1 each  result handshake, requester N.
REQ-010 resN_data  out  DATA_W  FIFO head for requester N.
REQ-011 busy  out  1  high while any issue is in flight or any FIFO is non-empty.

Function
REQ-012 A transfer on requester N SHALL occur on an edge where reqN_valid and reqN_ready are both high; at most one requester transfers per edge.
REQ-013 Requester N SHALL be eligible when reqN_valid is high and fifo_countN + inflightN < DEPTH (credit check), so that no FIFO ever overflows.
REQ-014 reqN_ready SHALL be high only for the granted requester; it SHALL NOT depend on reqN_valid of the same requester beyond eligibility.
REQ-015 Arbitration SHALL be round-robin: one eligible requester wins; both eligible -> the requester not granted last wins; last_grant updates only on a transfer.
REQ-016 On a transfer at edge k, mac_in_valid, mac_a and mac_b SHALL hold the transferred values during cycle k..k+1; mac_in_valid SHALL be low in cycles without a transfer.
REQ-017 A LAT-deep valid/tag shift register SHALL track issues; at edge k+LAT+1, mac_out SHALL be pushed into the FIFO of the tagged requester.
REQ-018 FIFOs SHALL be show-ahead: resN_valid is high when non-empty, and resN_data equals the oldest entry; pop on resN_valid & resN_ready.
REQ-019 Results SHALL return to each requester in issue order; minimum accept-to-resN_valid latency SHALL be LAT+1 cycles.
REQ-020 A simultaneous push and pop on the same FIFO SHALL leave the count unchanged and preserve order, including when the FIFO is full.
REQ-021 inflightN SHALL increment on issue and decrement on push; simultaneous issue and push for N SHALL leave it unchanged.
REQ-022 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-023 While rst is high at an edge: shift register cleared, inflight counts 0, FIFOs emptied, last_grant = 1 (req0 wins first tie).
REQ-024 During and after reset: reqN_ready=0, mac_in_valid=0, mac_a=mac_b=0, resN_valid=0, resN_data=0, busy=0 until the next transfer.
REQ-025 A reset during operation SHALL discard all in-flight operations; mac_out values arriving afterwards SHALL be ignored.

Configuration
REQ-026 With MAC_ARB_STATS_EN defined, outputs grant_cnt0 and grant_cnt1 (16 bits each) SHALL count transfers per requester, saturating at 0xFFFF and cleared by rst.
REQ-027 Without MAC_ARB_STATS_EN, these ports and counters SHALL be absent, and the rest of the behaviour SHALL be identical.

Verification
REQ-028 Single issue: req0 sends a=0x3C00, b=0x4000; the model returns 0x4000 LAT cycles later -> res0_valid rises 6 cycles after the accept edge with res0_data=0x4000; res1_valid stays 0.
REQ-029 Contention: req0 and req1 are valid continuously after reset -> grants alternate 0,1,0,1 on consecutive edges, and each requester receives its own results in order.
REQ-030 Backpressure: res0_ready=0, req0 streams operands -> exactly DEPTH=4 transfers, then req0_ready stays 0; raising res0_ready for one pop -> exactly one more transfer.
REQ-031 Full FIFO with simultaneous push and pop: the count stays at 4 and the data order is 1,2,3,4,5 for operand sequence 1..5.
REQ-032 Reset asserted with 3 ops in flight -> after reset, busy=0, no resN_valid, and stale mac_out values are never pushed.
REQ-033 With MAC_ARB_STATS_EN, 10 req0 and 7 req1 transfers -> grant_cnt0=10 and grant_cnt1=7; both are 0 after rst.
